// File: rtl/seq_stage_sequencer.sv
// Multi-cycle control FSM for the sequential RISC-V core: FETCH, DECODE, EXECUTE,
// optional MEM, WRITEBACK, plus sticky HALT/ERROR terminal states.
module seq_stage_sequencer #(
    parameter int unsigned           PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]   PC_LIMIT    = 32'h0000_0200,
    parameter int unsigned           MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                imem_ready,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                branch,
    input  logic                alu_zero,
    input  logic [63:0]         branch_offset,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_we,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                regfile_we,
    output logic                pc_we,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                halted,
    output logic                error,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [7:0]          wait_q, wait_d;
    logic                load_q, load_d;
    logic                store_q, store_d;
    logic                branch_q, branch_d;
    logic [PC_WIDTH-1:0] pc_next_q, pc_next_d;
    logic [63:0]         target;
    logic                taken;
    logic                target_unused;

    // Branch target is formed at full 64-bit width and then truncated to the PC.
    assign target        = 64'(pc) + (branch_offset << 1);
    assign target_unused = ^target[63:PC_WIDTH];
    assign taken         = branch_q & alu_zero;
    assign pc_next       = pc_next_q;
    assign state         = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wait_q    <= 8'd0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            branch_q  <= 1'b0;
            pc_next_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            load_q    <= load_d;
            store_q   <= store_d;
            branch_q  <= branch_d;
            pc_next_q <= pc_next_d;
        end
    end

    // Memory handshake: a request is held while in FETCH/MEM; the transfer completes in
    // the cycle the matching ready is sampled high, even if the wait budget ends then.
    always_comb begin
        state_d    = state_q;
        wait_d     = 8'd0;
        load_d     = load_q;
        store_d    = store_q;
        branch_d   = branch_q;
        pc_next_d  = pc_next_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        regfile_we = 1'b0;
        pc_we      = 1'b0;
        halted     = 1'b0;
        error      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                load_d   = is_load;
                store_d  = is_store;
                branch_d = branch;
                state_d  = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (taken && (target[1:0] != 2'b00)) begin
                    state_d = S_ERROR;
                end else begin
                    pc_next_d = taken ? target[PC_WIDTH-1:0] : pc + PC_WIDTH'(4);
                    state_d   = (load_q || store_q) ? S_MEM : S_WRITEBACK;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = store_q;
                if (dmem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WRITEBACK: begin
                regfile_we = ~(store_q | branch_q);
                // An out-of-range next PC is never committed; the core halts instead.
                if (pc_next_q < PC_LIMIT) begin
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: error  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// Self-checking bench for seq_stage_sequencer: directed vector table, random
// instructions against a transaction-level model, and reset-during-MEM sequence.
module tb_seq_stage_sequencer;

    localparam int          TO    = 15;
    localparam logic [31:0] LIMIT = 32'h0000_0200;

    logic        clk, reset, start;
    logic [31:0] pc;
    logic        imem_ready, is_load, is_store, branch, alu_zero, dmem_ready;
    logic [63:0] branch_offset;
    logic        imem_req, ir_we, dmem_req, dmem_we, regfile_we, pc_we, halted, error;
    logic [31:0] pc_next;
    logic [2:0]  state;

    seq_stage_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .imem_ready(imem_ready),
        .is_load(is_load), .is_store(is_store), .branch(branch), .alu_zero(alu_zero),
        .branch_offset(branch_offset), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .regfile_we(regfile_we),
        .pc_we(pc_we), .pc_next(pc_next), .halted(halted), .error(error), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        ld, st, br, az;
        logic [63:0] off;
        int          iw, dw;
    } instr_t;

    typedef struct {
        int          cycles;
        logic [31:0] pc_next;
        int          fin;
        int          ir_we, imem_req, dmem_req, dmem_we, rf_we, pc_we;
    } res_t;

    typedef struct {
        instr_t      in;
        int          cycles;
        logic [31:0] pc_next;
        int          fin;
        int          rf_we;
        int          pc_we;
    } vec_t;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] prev_pc_next;
    vec_t        vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Instruction-level reference: cycle count and strobe totals from the stage rules.
    function automatic res_t model(input instr_t in, input logic [31:0] prev);
        res_t        r;
        logic [63:0] tgt64;
        logic [31:0] tgt;
        logic        tk;
        r = '{default: 0};
        r.pc_next = prev;
        if (in.iw >= TO) begin
            r.cycles = TO; r.imem_req = TO; r.fin = 7;
            return r;
        end
        r.imem_req = in.iw + 1;
        r.ir_we    = 1;
        r.cycles   = in.iw + 1 + 2;
        tgt64 = {32'h0, in.pc} + in.off * 64'd2;
        tgt   = tgt64[31:0];
        tk    = in.br && in.az;
        if (tk && (tgt % 4 != 0)) begin
            r.fin = 7;
            return r;
        end
        r.pc_next = tk ? tgt : in.pc + 32'd4;
        if (in.ld || in.st) begin
            if (in.dw >= TO) begin
                r.cycles  += TO;
                r.dmem_req = TO;
                r.dmem_we  = in.st ? TO : 0;
                r.fin      = 7;
                return r;
            end
            r.cycles  += in.dw + 1;
            r.dmem_req = in.dw + 1;
            r.dmem_we  = in.st ? in.dw + 1 : 0;
        end
        r.cycles += 1;
        r.rf_we   = (in.st || in.br) ? 0 : 1;
        r.pc_we   = (r.pc_next < LIMIT) ? 1 : 0;
        r.fin     = r.pc_we ? 1 : 6;
        return r;
    endfunction

    task automatic do_reset_start();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        check("reset_state", 64'(state), 64'd0);
        check("reset_outs", 64'({imem_req, ir_we, dmem_req, dmem_we, regfile_we, pc_we, halted, error}), 64'd0);
        check("reset_pc_next", 64'(pc_next), 64'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_to_fetch", 64'(state), 64'd1);
        prev_pc_next = 32'h0;
    endtask

    // Runs one instruction starting in FETCH; memories answer after iw/dw wait cycles.
    task automatic run_instr(input instr_t in, output res_t r);
        int         iw_cnt = 0;
        int         dw_cnt = 0;
        logic       done   = 1'b0;
        logic [2:0] st;
        r = '{default: 0};
        pc = in.pc; is_load = in.ld; is_store = in.st; branch = in.br;
        alu_zero = in.az; branch_offset = in.off;
        for (int c = 0; c < 200 && !done; c++) begin
            imem_ready = imem_req && (iw_cnt == in.iw);
            dmem_ready = dmem_req && (dw_cnt == in.dw);
            if (imem_req) iw_cnt++;
            if (dmem_req) dw_cnt++;
            #1;
            st = state;
            if (st == 3'd6 || st == 3'd7) begin
                done = 1'b1;
            end else begin
                r.cycles++;
                r.ir_we    += int'(ir_we);
                r.imem_req += int'(imem_req);
                r.dmem_req += int'(dmem_req);
                r.dmem_we  += int'(dmem_we);
                r.rf_we    += int'(regfile_we);
                r.pc_we    += int'(pc_we);
                @(negedge clk);
                if (st == 3'd5) begin
                    imem_ready = 1'b0; dmem_ready = 1'b0;
                    #1;
                    done = 1'b1;
                end
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL instr_timeout: got no completion after 200 cycles, expected completion");
        end
        r.pc_next = pc_next;
        r.fin     = int'(state);
        if (r.fin == 6 || r.fin == 7) begin
            check("terminal_flags", 64'({halted, error}), (r.fin == 6) ? 64'd2 : 64'd1);
            check("terminal_strobes", 64'({imem_req, ir_we, dmem_req, dmem_we, regfile_we, pc_we}), 64'd0);
        end
    endtask

    task automatic compare_model(input string tag, input res_t a, input res_t e);
        check({tag, "_cycles"},   64'(a.cycles),   64'(e.cycles));
        check({tag, "_pc_next"},  64'(a.pc_next),  64'(e.pc_next));
        check({tag, "_state"},    64'(a.fin),      64'(e.fin));
        check({tag, "_ir_we"},    64'(a.ir_we),    64'(e.ir_we));
        check({tag, "_imem_req"}, 64'(a.imem_req), 64'(e.imem_req));
        check({tag, "_dmem_req"}, 64'(a.dmem_req), 64'(e.dmem_req));
        check({tag, "_dmem_we"},  64'(a.dmem_we),  64'(e.dmem_we));
        check({tag, "_rf_we"},    64'(a.rf_we),    64'(e.rf_we));
        check({tag, "_pc_we"},    64'(a.pc_we),    64'(e.pc_we));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t in;
        res_t   r, e;
        int     o;
        logic signed [63:0] so;
        int     last_fin;

        reset = 1'b1; start = 1'b0; pc = '0; imem_ready = 1'b0; is_load = 1'b0;
        is_store = 1'b0; branch = 1'b0; alu_zero = 1'b0; branch_offset = '0; dmem_ready = 1'b0;

        //                pc            ld    st    br    az    offset                 iw  dw   cyc  pc_next       fin rf pcwe
        vecs[0]  = '{'{32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0,                  0,  0},  4, 32'h0000_0004, 1, 1, 1};
        vecs[1]  = '{'{32'h040, 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 0,  0},  4, 32'h0000_0030, 1, 0, 1};
        vecs[2]  = '{'{32'h040, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 0,  0},  4, 32'h0000_0044, 1, 0, 1};
        vecs[3]  = '{'{32'h080, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0,                  0,  2},  7, 32'h0000_0084, 1, 1, 1};
        vecs[4]  = '{'{32'h084, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,                  0,  0},  5, 32'h0000_0088, 1, 0, 1};
        vecs[5]  = '{'{32'h1F8, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0,                  0,  0},  4, 32'h0000_01FC, 1, 1, 1};
        vecs[6]  = '{'{32'h1FC, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0,                  0,  0},  4, 32'h0000_0200, 6, 1, 0};
        vecs[7]  = '{'{32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0,                 15,  0}, 15, 32'h0000_0000, 7, 0, 0};
        vecs[8]  = '{'{32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0,                 14,  0}, 18, 32'h0000_0104, 1, 1, 1};
        vecs[9]  = '{'{32'h010, 1'b0, 1'b0, 1'b1, 1'b1, 64'd1,                  0,  0},  3, 32'h0000_0104, 7, 0, 0};
        vecs[10] = '{'{32'h020, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0,                  0, 14}, 19, 32'h0000_0024, 1, 1, 1};
        vecs[11] = '{'{32'h024, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0,                  0, 15}, 18, 32'h0000_0028, 7, 0, 0};
        vecs[12] = '{'{32'h008, 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 0,  0},  4, 32'hFFFF_FFF8, 6, 0, 0};
        vecs[13] = '{'{32'h1F0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd6,                  0,  0},  4, 32'h0000_01FC, 1, 0, 1};

        do_reset_start();
        last_fin = 1;
        for (int i = 0; i < 14; i++) begin
            if (last_fin == 6 || last_fin == 7) do_reset_start();
            run_instr(vecs[i].in, r);
            check($sformatf("vec%0d_cycles", i),  64'(r.cycles),  64'(vecs[i].cycles));
            check($sformatf("vec%0d_pc_next", i), 64'(r.pc_next), 64'(vecs[i].pc_next));
            check($sformatf("vec%0d_state", i),   64'(r.fin),     64'(vecs[i].fin));
            check($sformatf("vec%0d_rf_we", i),   64'(r.rf_we),   64'(vecs[i].rf_we));
            check($sformatf("vec%0d_pc_we", i),   64'(r.pc_we),   64'(vecs[i].pc_we));
            if (r.fin == 6) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                #1;
                check("halt_ignores_start", 64'(state), 64'd6);
            end
            prev_pc_next = vecs[i].pc_next;
            last_fin = vecs[i].fin;
        end

        // Random instructions checked against the instruction-level model.
        for (int i = 0; i < 150; i++) begin
            if (last_fin == 6 || last_fin == 7) do_reset_start();
            in.pc = 32'($urandom_range(0, 135)) << 2;
            o     = $urandom_range(0, 3);
            in.ld = (o == 1); in.st = (o == 2); in.br = (o == 3);
            in.az = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                in.off = {$urandom, $urandom};
            end else begin
                so = int'($urandom_range(0, 80)) - 40;
                in.off = so;
            end
            in.iw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 2));
            in.dw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 2));
            e = model(in, prev_pc_next);
            run_instr(in, r);
            compare_model($sformatf("rnd%0d", i), r, e);
            prev_pc_next = e.pc_next;
            last_fin = e.fin;
        end

        // Reset asserted mid-MEM must clear outputs without waiting for a clock edge.
        do_reset_start();
        pc = 32'h60; is_load = 1'b1; is_store = 1'b0; branch = 1'b0; alu_zero = 1'b0;
        branch_offset = '0; imem_ready = 1'b1; dmem_ready = 1'b0;
        for (int c = 0; c < 20 && state != 3'd4; c++) begin
            @(negedge clk);
            #1;
        end
        check("reach_mem", 64'({state, dmem_req}), 64'({3'd4, 1'b1}));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_state", 64'(state), 64'd0);
        check("async_reset_outs", 64'({imem_req, ir_we, dmem_req, dmem_we, regfile_we, pc_we, halted, error}), 64'd0);
        @(negedge clk);
        reset = 1'b0; imem_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("restart_fetch", 64'(state), 64'd1);
        in = '{32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 0, 0};
        e = model(in, 32'h0);
        run_instr(in, r);
        compare_model("post_reset", r, e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_stage_sequencer.md
Name: seq_stage_sequencer

Overview:
Multi-cycle control FSM for the sequential (SEQ) RISC-V core. It steps each instruction through FETCH, DECODE, EXECUTE, optional MEM, and WRITEBACK. It handshakes with instruction and data memory, and computes and commits the next PC (sequential or branch target). It replaces simulation-only program termination with a synthesizable HALT state, and adds an ERROR state for memory timeouts and misaligned targets.

Parameters:
PC_WIDTH, 32, width of PC and pc_next.
PC_LIMIT, 32'h0000_0200, first illegal PC (128 instructions x 4 bytes).
MEM_TIMEOUT, 15, max wait cycles per memory request before ERROR (1..255).

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  leave IDLE and begin fetching at current pc
pc  in  PC_WIDTH  current PC from the PC register
imem_ready  in  1  instruction memory data valid
is_load  in  1  decoded load, sampled in DECODE
is_store  in  1  decoded store, sampled in DECODE
branch  in  1  decoded branch, sampled in DECODE
alu_zero  in  1  ALU zero flag, sampled in EXECUTE
branch_offset  in  64  sign-extended immediate, sampled in EXECUTE
dmem_ready  in  1  data memory access complete
imem_req  out  1  fetch request
ir_we  out  1  instruction register write strobe
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
regfile_we  out  1  register file write strobe
pc_we  out  1  PC register write strobe
pc_next  out  PC_WIDTH  registered next-PC value
halted  out  1  program completed (sticky)
error  out  1  fault (sticky)
state  out  3  current state encoding, for debug

Behaviour:
- Reset: state=IDLE, pc_next=0, wait counter=0, latched flags=0, all strobes/halted/error=0. Reset applies in any state, including mid-handshake.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6, ERROR=7.
- Output decoding: all outputs are decoded from the state register, except ir_we, which is Mealy.
- IDLE: start=1 -> FETCH. start is ignored in every other state.
- FETCH:
  - imem_req=1.
  - imem_ready=1 -> ir_we=1 (same cycle), counter cleared, go to DECODE.
  - Otherwise counter+1; counter==MEM_TIMEOUT-1 with no ready -> ERROR.
- DECODE: latch is_load, is_store, branch into flags -> EXECUTE.
- EXECUTE:
  - Taken when branch_flag & alu_zero: target = pc + (branch_offset << 1), computed in 64 bits, then truncated to PC_WIDTH. The shift is applied before the add.
  - Not taken: pc_next <= pc + 4, modulo 2^PC_WIDTH.
  - Taken with target[1:0]!=0 -> ERROR, and pc_next is not updated.
  - Otherwise: load or store -> MEM; else -> WRITEBACK.
- MEM:
  - dmem_req=1, dmem_we=is_store flag.
  - dmem_ready=1 -> WRITEBACK.
  - Timeout rule is identical to FETCH: the counter is cleared on entry.
- WRITEBACK:
  - regfile_we=1 unless the store or branch flag is set.
  - pc_next < PC_LIMIT -> pc_we=1, go to FETCH.
  - pc_next >= PC_LIMIT -> pc_we=0, go to HALT. The PC is never written with an out-of-range value.
- HALT: halted=1, all strobes 0, stays until reset.
- ERROR: error=1, all strobes 0, stays until reset.
- Latency with zero-wait memories:
  - ALU/branch instruction: 4 cycles (F, D, E, WB).
  - Load/store: 5 cycles.
  - Each memory wait cycle adds 1.
- Boundary rules:
  - Ready asserted in the same cycle the timeout expires counts as success.
  - A negative offset that wraps below 0 is truncated and then range-checked like any other value.
  - pc_next == PC_LIMIT-4 is legal.
  - Reset during MEM drops dmem_req asynchronously.

Test Plan:
1. reset, pc=0, start pulse, imem_ready=1, no load/store/branch -> states 1,2,3,5; ir_we in cycle 1; regfile_we and pc_we in cycle 4; pc_next=0x4; back to FETCH.
2. pc=0x40, branch=1, alu_zero=1, branch_offset=-8 -> pc_next=0x30, pc_we=1, regfile_we=0. Same with alu_zero=0 -> pc_next=0x44.
3. Load with dmem_ready delayed 2 cycles -> dmem_req high 3 cycles, dmem_we=0, total 7 cycles. Store -> dmem_we=1, regfile_we=0.
4. imem_ready held 0 -> ERROR after exactly MEM_TIMEOUT FETCH cycles, error=1, imem_req=0. Branch offset=1 (target misaligned) -> ERROR from EXECUTE.
5. pc=0x1FC, sequential instruction -> pc_next=0x200, pc_we never asserted, HALT, halted=1. pc=0x1F8 -> pc_next=0x1FC, continues to FETCH.
6. Assert reset mid-MEM while dmem_req=1 -> all outputs 0 immediately, state=IDLE. start afterwards -> normal FETCH.
